// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral.
//   spi_state_e : frame FSM states
//   frame_len() : bits in one well-formed frame (rw + address + data)
//   RW_WRITE / RW_READ : values of the leading rw bit
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      HOLD,
      ERR
   } spi_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   function automatic int unsigned frame_len(input int unsigned addr_w,
                                             input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for the asynchronous SPI pins.
//   clk, rst_n          : system clock, async active-low reset
//   sclk, ncs, copi     : raw SPI pins
//   ncs_s, copi_s       : synchronised levels (last stage)
//   sclk_rise/sclk_fall : one-clk registered edge strobes of sCLK
//   ncs_rise/ncs_fall   : one-clk registered edge strobes of nCS
// Edge strobes are formed from the last two stages and registered, so each
// strobe is high in the same cycle the last stage shows the new level.
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic ncs,
   input  logic copi,
   output logic ncs_s,
   output logic copi_s,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ncs_rise,
   output logic ncs_fall
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] ncs_sr;
   logic [SYNC_STAGES-1:0] copi_sr;

   // nCS resets high (deselected) so no spurious fall or output enable after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sr   <= '0;
         ncs_sr    <= '1;
         copi_sr   <= '0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         ncs_rise  <= 1'b0;
         ncs_fall  <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         ncs_sr    <= {ncs_sr[SYNC_STAGES-2:0], ncs};
         copi_sr   <= {copi_sr[SYNC_STAGES-2:0], copi};
         sclk_rise <=  sclk_sr[SYNC_STAGES-2] & ~sclk_sr[SYNC_STAGES-1];
         sclk_fall <= ~sclk_sr[SYNC_STAGES-2] &  sclk_sr[SYNC_STAGES-1];
         ncs_rise  <=  ncs_sr[SYNC_STAGES-2]  & ~ncs_sr[SYNC_STAGES-1];
         ncs_fall  <= ~ncs_sr[SYNC_STAGES-2]  &  ncs_sr[SYNC_STAGES-1];
      end
   end

   assign ncs_s  = ncs_sr[SYNC_STAGES-1];
   assign copi_s = copi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral, oversampled on the system clock.
//   clk, rst_n : system clock, async active-low reset
//   sCLK, nCS, COPI : SPI pins from the controller
//   CIPO, cipo_oe   : read data out and its output enable (enabled while selected)
//   regs_q    : flattened register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse  : one-clk strobe, bit i on the cycle reg i is written
//   frame_err : one-clk strobe when a malformed frame is discarded
// Frame, MSB first: rw (1=write), address, data. Writes commit atomically on
// nCS rise; out-of-range addresses read as zero and ignore writes.
module spi_regfile_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 5,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sCLK,
   input  logic                       nCS,
   input  logic                       COPI,
   output logic                       CIPO,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_q,
   output logic [NUM_REGS-1:0]        wr_pulse,
   output logic                       frame_err
);

   localparam int unsigned FRAME_LEN = frame_len(ADDR_W, DATA_W);
   localparam int unsigned HDR_W     = 1 + ADDR_W;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);

   localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN + 1);

   logic ncs_s, copi_s, sclk_rise, sclk_fall, ncs_rise, ncs_fall;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sCLK),
      .ncs       (nCS),
      .copi      (COPI),
      .ncs_s     (ncs_s),
      .copi_s    (copi_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ncs_rise  (ncs_rise),
      .ncs_fall  (ncs_fall)
   );

   spi_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [HDR_W-1:0]    hdr_q, hdr_d, hdr_shift;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   shadow_q, shadow_d;
   logic                cipo_q, cipo_d;
   logic                commit, ferr;
   logic [DATA_W-1:0]   rd_word;
   logic [ADDR_W-1:0]   addr_q;
   logic                addr_ok;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   assign addr_q    = hdr_q[ADDR_W-1:0];
   assign addr_ok   = 32'(addr_q) < NUM_REGS;
   assign hdr_shift = (hdr_q << 1) | HDR_W'(copi_s);
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Read lookup uses the address including the bit arriving this cycle,
   // so the shadow is ready before the first CIPO falling edge.
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (32'(hdr_shift[ADDR_W-1:0]) == i) rd_word = regs[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hdr_d    = hdr_q;
      data_d   = data_q;
      shadow_d = shadow_q;
      cipo_d   = cipo_q;
      commit   = 1'b0;
      ferr     = 1'b0;
      if (ncs_fall) begin
         // Restart from any state: a select glitch begins a fresh frame.
         state_d  = ADDR;
         cnt_d    = '0;
         hdr_d    = '0;
         data_d   = '0;
         shadow_d = '0;
      end else if (ncs_rise) begin
         state_d = IDLE;
         case (state_q)
            ADDR, DATA, ERR: ferr   = 1'b1;
            HOLD:            commit = (hdr_q[HDR_W-1] == RW_WRITE) && addr_ok;
            default:         ;
         endcase
      end else begin
         case (state_q)
            ADDR: begin
               if (sclk_rise) begin
                  hdr_d = hdr_shift;
                  cnt_d = cnt_inc;
                  if (cnt_q == LAST_HDR) begin
                     state_d = DATA;
                     if (hdr_shift[HDR_W-1] == RW_READ) shadow_d = rd_word;
                  end
               end
            end
            DATA: begin
               if (sclk_rise) begin
                  data_d = (data_q << 1) | DATA_W'(copi_s);
                  cnt_d  = cnt_inc;
                  if (cnt_q == LAST_BIT) state_d = HOLD;
               end else if (sclk_fall) begin
                  cipo_d   = shadow_q[DATA_W-1];
                  shadow_d = shadow_q << 1;
               end
            end
            HOLD: begin
               if (sclk_rise) begin
                  cnt_d   = cnt_inc;
                  state_d = ERR;
               end
            end
            ERR: begin
               if (sclk_rise) cnt_d = cnt_inc;
            end
            default: ;
         endcase
      end
      if (state_d != DATA) cipo_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hdr_q    <= '0;
         data_q   <= '0;
         shadow_q <= '0;
         cipo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hdr_q    <= hdr_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         cipo_q   <= cipo_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         wr_pulse  <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_pulse  <= '0;
         frame_err <= ferr;
         if (commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               if (32'(addr_q) == i) begin
                  regs[i]     <= data_q;
                  wr_pulse[i] <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      regs_q = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i*DATA_W +: DATA_W] = regs[i];
   end

   assign CIPO    = cipo_q;
   assign cipo_oe = ~ncs_s;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;

   localparam int NR = 5;
   localparam int DW = 8;
   localparam int HALF = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           sCLK = 1'b0;
   logic           nCS = 1'b1;
   logic           COPI = 1'b0;
   logic           CIPO;
   logic           cipo_oe;
   logic [NR*DW-1:0] regs_q;
   logic [NR-1:0]  wr_pulse;
   logic           frame_err;

   spi_regfile_peripheral #(
      .NUM_REGS    (NR),
      .ADDR_W      (7),
      .DATA_W      (DW),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sCLK      (sCLK),
      .nCS       (nCS),
      .COPI      (COPI),
      .CIPO      (CIPO),
      .cipo_oe   (cipo_oe),
      .regs_q    (regs_q),
      .wr_pulse  (wr_pulse),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int wr_cycles = 0;
   int ferr_cycles = 0;
   logic [NR-1:0] last_wr = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (|wr_pulse) begin
            wr_cycles = wr_cycles + 1;
            last_wr = wr_pulse;
         end
         if (frame_err) ferr_cycles = ferr_cycles + 1;
      end
   end

   logic [DW-1:0] model [NR];

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      f = '0;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
      return f;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Drives nbits of frame MSB first; stops early (nCS left low) at bit stop_at.
   task automatic spi_send(input logic [31:0] frame, input int nbits, input int stop_at,
                           output logic [DW-1:0] rx);
      rx = '0;
      nCS = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         if (k == stop_at) return;
         COPI = frame[nbits-1-k];
         wait_clk(HALF);
         if (k == 0) check("cipo_oe_selected", cipo_oe, 1'b1);
         if (k >= 8 && k < 16) rx = {rx[DW-2:0], CIPO};
         sCLK = 1'b1;
         wait_clk(HALF);
         sCLK = 1'b0;
      end
      wait_clk(HALF);
      nCS = 1'b1;
      COPI = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits, input int gap);
      int wc0, fc0;
      logic [31:0] frame;
      logic [DW-1:0] rx, exp_rx;
      logic is_write;
      wc0 = wr_cycles;
      fc0 = ferr_cycles;
      frame = {16'h0, rw, addr, data};
      // Extend or truncate around the 16-bit core frame.
      if (nbits > 16) frame = (frame << (nbits - 16)) | 32'h1;
      else if (nbits < 16) frame = frame >> (16 - nbits);
      exp_rx = (int'(addr) < NR) ? model[addr] : 8'h00;
      spi_send(frame, nbits, -1, rx);
      wait_clk(gap);
      is_write = (nbits == 16) && rw && (int'(addr) < NR);
      if (is_write) model[addr] = data;
      check({tag, "_regs"}, regs_q, model_flat());
      check({tag, "_wr_cycles"}, wr_cycles - wc0, is_write ? 1 : 0);
      if (is_write) check({tag, "_wr_bit"}, last_wr, NR'(1) << addr);
      check({tag, "_frame_err"}, ferr_cycles - fc0, (nbits == 16) ? 0 : 1);
      check({tag, "_cipo_oe_idle"}, cipo_oe, 1'b0);
      if (nbits == 16 && !rw) check({tag, "_rx"}, rx, exp_rx);
   endtask

   initial begin
      logic [DW-1:0] dummy;
      logic rw;
      logic [6:0] addr;
      for (int i = 0; i < NR; i++) model[i] = '0;

      // Reset state
      wait_clk(3);
      check("rst_regs", regs_q, '0);
      check("rst_wr_pulse", wr_pulse, '0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_cipo", CIPO, 1'b0);
      check("rst_cipo_oe", cipo_oe, 1'b0);
      rst_n = 1'b1;
      wait_clk(4);

      // 1. basic write to reg0
      run_frame("t1_wr0", 1'b1, 7'h00, 8'hA5, 16, 6);
      // 2. write reg4 then read it back on CIPO
      run_frame("t2_wr4", 1'b1, 7'h04, 8'h3C, 16, 6);
      run_frame("t2_rd4", 1'b0, 7'h04, 8'h55, 16, 6);
      // 3. out-of-range write and read
      run_frame("t3_wr5", 1'b1, 7'h05, 8'hFF, 16, 6);
      run_frame("t3_rd7f", 1'b0, 7'h7F, 8'h00, 16, 6);
      // 4. malformed frames
      run_frame("t4_short", 1'b1, 7'h02, 8'h77, 15, 6);
      run_frame("t4_long", 1'b1, 7'h02, 8'h77, 17, 6);

      // 5. reset mid-frame
      spi_send({16'h0, 1'b1, 7'h01, 8'hEE}, 16, 10, dummy);
      rst_n = 1'b0;
      #1;
      check("t5_rst_regs", regs_q, '0);
      check("t5_rst_wr_pulse", wr_pulse, '0);
      check("t5_rst_frame_err", frame_err, 1'b0);
      check("t5_rst_cipo", CIPO, 1'b0);
      check("t5_rst_cipo_oe", cipo_oe, 1'b0);
      for (int i = 0; i < NR; i++) model[i] = '0;
      nCS = 1'b1;
      sCLK = 1'b0;
      COPI = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      run_frame("t5_wr1", 1'b1, 7'h01, 8'h81, 16, 6);

      // 6. back-to-back writes with a 4-clk deselect gap
      run_frame("t6_wr2", 1'b1, 7'h02, 8'h0F, 16, 4);
      run_frame("t6_wr3", 1'b1, 7'h03, 8'hF0, 16, 4);
      wait_clk(4);

      // Randomised frames against the model
      for (int n = 0; n < 24; n++) begin
         rw = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, NR - 1));
         run_frame("rnd", rw, addr, 8'($urandom), 16, 6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: observed=no finish expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
